// File: rtl/nic2noc_vc_scheduler_pkg.sv
// Shared constants, FSM encodings and helpers for the NIC-to-NoC VC scheduler.
// Sizing: 2 VNs x 3 VCs, 64-bit flits, 8 output buffers, 4 credits per VC.
package nic2noc_vc_scheduler_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int N_OF_VN           = 2;
    localparam int N_OF_VC           = 3;
    localparam int N_TOT_OF_VC       = N_OF_VC * N_OF_VN;
    localparam int FLIT_WIDTH        = 64;
    localparam int N_FIFO_OUT_BUFFER = 8;
    localparam int N_BITS_POINTER    = clog2(N_FIFO_OUT_BUFFER);
    localparam int CREDIT_DEPTH      = 4;
    localparam int N_BITS_CREDIT     = clog2(CREDIT_DEPTH + 1);

    typedef logic [1:0] vc_fsm_t;

    localparam vc_fsm_t VC_FREE      = 2'd0;
    localparam vc_fsm_t VC_BOUND     = 2'd1;
    localparam vc_fsm_t VC_WAIT_FREE = 2'd2;

endpackage

// File: rtl/nic2noc_vc_scheduler_if.sv
// Bundle between the NIC (master) and the VC scheduler (slave).
// Carries bind, flit request/ack, credit/free returns and the NoC link.
interface nic2noc_vc_scheduler_if
    import nic2noc_vc_scheduler_pkg::*;
;
    logic [N_TOT_OF_VC-1:0]                bind_i;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] bind_buffer_id_i;
    logic [N_TOT_OF_VC-1:0]                flit_req_i;
    logic [N_TOT_OF_VC*FLIT_WIDTH-1:0]     flit_data_i;
    logic [N_TOT_OF_VC-1:0]                flit_tail_i;
    logic [N_TOT_OF_VC-1:0]                flit_ack_o;
    logic [N_TOT_OF_VC*N_BITS_POINTER-1:0] fifo_pointed_o;
    logic [N_TOT_OF_VC-1:0]                credit_signal_i;
    logic [N_TOT_OF_VC-1:0]                free_signal_i;
    logic [FLIT_WIDTH-1:0]                 out_link_o;
    logic                                  is_valid_o;
    logic [N_TOT_OF_VC-1:0]                out_vc_o;
    logic [N_TOT_OF_VC-1:0]                vc_state_o;

    modport slave (
        input  bind_i, bind_buffer_id_i, flit_req_i, flit_data_i,
        input  flit_tail_i, credit_signal_i, free_signal_i,
        output flit_ack_o, fifo_pointed_o, out_link_o, is_valid_o,
        output out_vc_o, vc_state_o
    );

    modport master (
        output bind_i, bind_buffer_id_i, flit_req_i, flit_data_i,
        output flit_tail_i, credit_signal_i, free_signal_i,
        input  flit_ack_o, fifo_pointed_o, out_link_o, is_valid_o,
        input  out_vc_o, vc_state_o
    );

endinterface

// File: rtl/nic2noc_vc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr.
// Ports: i_req request vector, i_ptr pointer; o_grant one-hot, o_ptr_nxt, o_any.
module nic2noc_vc_scheduler_rr_arbiter
    import nic2noc_vc_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        i_req,
    input  logic [clog2(N)-1:0] i_ptr,
    output logic [N-1:0]        o_grant,
    output logic [clog2(N)-1:0] o_ptr_nxt,
    output logic                o_any
);
    localparam int PW = clog2(N);
    localparam int W  = PW + 1;

    logic [W-1:0] w_idx;

    always_comb begin
        o_grant   = '0;
        o_any     = 1'b0;
        o_ptr_nxt = i_ptr;
        w_idx     = '0;
        for (int i = 0; i < N; i++) begin
            // wrap ptr+i back into 0..N-1 (N need not be a power of two)
            w_idx = W'(i_ptr) + W'(i);
            if (w_idx >= W'(N)) w_idx = w_idx - W'(N);
            if (!o_any && i_req[w_idx[PW-1:0]]) begin
                o_any                  = 1'b1;
                o_grant[w_idx[PW-1:0]] = 1'b1;
                o_ptr_nxt = (w_idx[PW-1:0] == PW'(N - 1)) ?
                            '0 : w_idx[PW-1:0] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nic2noc_vc_scheduler.sv
// NIC-to-NoC output stage: VC binding, per-VC credits, RR arbitration,
// registered flit/VC/valid on the link. Ports: clk, rst (sync, active-low),
// io_nic (slave modport). NIC_CREDIT_LOOKAHEAD_EN lets a same-cycle credit
// return make a zero-credit VC eligible.
module nic2noc_vc_scheduler
    import nic2noc_vc_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    nic2noc_vc_scheduler_if.slave  io_nic
);
    localparam int PW = clog2(N_TOT_OF_VC);
    localparam logic [N_BITS_CREDIT-1:0] CRED_FULL = N_BITS_CREDIT'(CREDIT_DEPTH);

    vc_fsm_t                   r_state  [N_TOT_OF_VC];
    logic [N_BITS_POINTER-1:0] r_id     [N_TOT_OF_VC];
    logic [N_BITS_CREDIT-1:0]  r_credit [N_TOT_OF_VC];
    logic [PW-1:0]             r_ptr;
    logic [FLIT_WIDTH-1:0]     r_out_link;
    logic                      r_valid;
    logic [N_TOT_OF_VC-1:0]    r_out_vc;

    logic [N_TOT_OF_VC-1:0]    w_elig;
    logic [N_TOT_OF_VC-1:0]    w_grant;
    logic                      w_any;
    logic [PW-1:0]             w_ptr_nxt;
    logic [FLIT_WIDTH-1:0]     w_flit;

    always_comb begin
        w_elig = '0;
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
`ifdef NIC_CREDIT_LOOKAHEAD_EN
            w_elig[v] = (r_state[v] == VC_BOUND) && io_nic.flit_req_i[v] &&
                        ((r_credit[v] != '0) || io_nic.credit_signal_i[v]);
`else
            w_elig[v] = (r_state[v] == VC_BOUND) && io_nic.flit_req_i[v] &&
                        (r_credit[v] != '0);
`endif
        end
    end

    nic2noc_vc_scheduler_rr_arbiter #(.N(N_TOT_OF_VC)) u_arb (
        .i_req     (w_elig),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_ptr_nxt (w_ptr_nxt),
        .o_any     (w_any)
    );

    always_comb begin
        io_nic.fifo_pointed_o = '0;
        io_nic.vc_state_o     = '0;
        w_flit                = '0;
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            io_nic.fifo_pointed_o[v*N_BITS_POINTER +: N_BITS_POINTER] = r_id[v];
            io_nic.vc_state_o[v] = (r_state[v] == VC_FREE);
            if (w_grant[v])
                w_flit = w_flit | io_nic.flit_data_i[v*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    // Ack is masked while reset is asserted: the grant comes from stale state.
    assign io_nic.flit_ack_o = rst ? w_grant : '0;
    assign io_nic.out_link_o = r_out_link;
    assign io_nic.is_valid_o = r_valid;
    assign io_nic.out_vc_o   = r_out_vc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr      <= '0;
            r_valid    <= 1'b0;
            r_out_vc   <= '0;
            r_out_link <= '0;
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                r_state[v]  <= VC_FREE;
                r_id[v]     <= '0;
                r_credit[v] <= CRED_FULL;
            end
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_valid  <= w_any;
            r_out_vc <= w_grant;
            if (w_any) r_out_link <= w_flit;
            for (int v = 0; v < N_TOT_OF_VC; v++) begin
                unique case (r_state[v])
                    VC_FREE: begin
                        if (io_nic.bind_i[v]) begin
                            r_state[v] <= VC_BOUND;
                            r_id[v] <= io_nic.bind_buffer_id_i[v*N_BITS_POINTER +: N_BITS_POINTER];
                        end
                    end
                    VC_BOUND: begin
                        if (w_grant[v] && io_nic.flit_tail_i[v])
                            r_state[v] <= VC_WAIT_FREE;
                    end
                    VC_WAIT_FREE: begin
                        if (io_nic.free_signal_i[v]) r_state[v] <= VC_FREE;
                    end
                    default: r_state[v] <= VC_FREE;
                endcase
                // grant and return together cancel out
                if (w_grant[v] && !io_nic.credit_signal_i[v])
                    r_credit[v] <= r_credit[v] - 1'b1;
                else if (!w_grant[v] && io_nic.credit_signal_i[v] &&
                         r_credit[v] != CRED_FULL)
                    r_credit[v] <= r_credit[v] + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        for (int v = 0; v < N_TOT_OF_VC; v++) begin
            assert (!(rst && io_nic.credit_signal_i[v] && !w_grant[v] &&
                      r_credit[v] == CRED_FULL))
                else $error("credit overflow on VC %0d", v);
        end
    end
`endif

endmodule

// File: tb/tb_nic2noc_vc_scheduler.sv
// Directed scoreboard bench for nic2noc_vc_scheduler.
// Stimulus pushes expected link flits; a monitor pops them on the link.
module tb_nic2noc_vc_scheduler;
    import nic2noc_vc_scheduler_pkg::*;

    typedef struct packed {
        logic [5:0]  vc;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nic2noc_vc_scheduler_if u_if();

    nic2noc_vc_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .io_nic (u_if.slave)
    );

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          seq = 0;
    logic        mon_en = 1'b0;
    logic        rst_s;
    logic [63:0] last_link = '0;
    exp_t        e;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: fresh flit data, check the ack, queue the expected flit.
    task automatic cyc(input string name, input logic [5:0] exp_ack);
        logic [63:0] d [6];
        exp_t x;
        for (int v = 0; v < 6; v++) begin
            d[v] = {8'hA0 + 8'(v), 40'h0, 16'(seq)};
            u_if.flit_data_i[v*64 +: 64] = d[v];
        end
        seq++;
        #1;
        chk({name, " ack"}, {58'h0, u_if.flit_ack_o}, {58'h0, exp_ack});
        for (int v = 0; v < 6; v++) begin
            if (exp_ack[v]) begin
                x.vc   = exp_ack;
                x.data = d[v];
                sb_q.push_back(x);
            end
        end
        @(posedge clk);
        #2;
    endtask

    always begin
        @(posedge clk);
        rst_s = rst;
        #1;
        if (mon_en) begin
            if (!rst_s) last_link = '0;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("link valid", {63'h0, u_if.is_valid_o}, 64'h1);
                chk("link vc", {58'h0, u_if.out_vc_o}, {58'h0, e.vc});
                chk("link data", u_if.out_link_o, e.data);
                last_link = e.data;
            end else begin
                chk("idle valid", {63'h0, u_if.is_valid_o}, 64'h0);
                chk("idle link hold", u_if.out_link_o, last_link);
            end
        end
    end

    initial begin
        u_if.bind_i           = '0;
        u_if.bind_buffer_id_i = '0;
        u_if.flit_req_i       = '0;
        u_if.flit_data_i      = '0;
        u_if.flit_tail_i      = '0;
        u_if.credit_signal_i  = '0;
        u_if.free_signal_i    = '0;
        rst = 1'b0;
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        cyc("reset", 6'b000000);
        chk("rst vc_state", {58'h0, u_if.vc_state_o}, 64'h3F);
        chk("rst fifo", {46'h0, u_if.fifo_pointed_o}, 64'h0);
        chk("rst out_vc", {58'h0, u_if.out_vc_o}, 64'h0);
        chk("rst link", u_if.out_link_o, 64'h0);
        rst = 1'b1;

        // 1: bind VC1->3, VC3->1, alternate
        u_if.bind_i = 6'b001010;
        u_if.bind_buffer_id_i[3 +: 3] = 3'd3;
        u_if.bind_buffer_id_i[9 +: 3] = 3'd1;
        cyc("t1 bind", 6'b000000);
        u_if.bind_i = '0;
        chk("t1 vc_state", {58'h0, u_if.vc_state_o}, 64'h35);
        chk("t1 id vc1", {61'h0, u_if.fifo_pointed_o[3 +: 3]}, 64'd3);
        chk("t1 id vc3", {61'h0, u_if.fifo_pointed_o[9 +: 3]}, 64'd1);
        u_if.flit_req_i = 6'b001010;
        cyc("t1 g0", 6'b000010);
        cyc("t1 g1", 6'b001000);
        cyc("t1 g2", 6'b000010);
        cyc("t1 g3", 6'b001000);
        u_if.flit_req_i = '0;
        u_if.credit_signal_i = 6'b001010;
        cyc("t1 ret0", 6'b000000);
        cyc("t1 ret1", 6'b000000);
        u_if.credit_signal_i = '0;

        // 2: VC0 exhausts its credits
        u_if.bind_i = 6'b000001;
        u_if.bind_buffer_id_i[0 +: 3] = 3'd2;
        cyc("t2 bind", 6'b000000);
        u_if.bind_i = '0;
        u_if.flit_req_i = 6'b000001;
        for (int i = 0; i < 4; i++) cyc("t2 send", 6'b000001);
        cyc("t2 stall", 6'b000000);
        u_if.credit_signal_i = 6'b000001;
`ifdef NIC_CREDIT_LOOKAHEAD_EN
        cyc("t2 lookahead", 6'b000001);
        u_if.credit_signal_i = '0;
`else
        cyc("t2 cred wait", 6'b000000);
        u_if.credit_signal_i = '0;
        cyc("t2 fifth", 6'b000001);
`endif
        u_if.flit_req_i = '0;
        u_if.credit_signal_i = 6'b000001;
        for (int i = 0; i < 4; i++) cyc("t2 refill", 6'b000000);
        u_if.credit_signal_i = '0;

        // 3: tail, free in tail cycle ignored, free, rebind to 5
        u_if.flit_req_i = 6'b000001;
        u_if.flit_tail_i = 6'b000001;
        u_if.free_signal_i = 6'b000001;
        cyc("t3 tail", 6'b000001);
        u_if.flit_req_i = '0;
        u_if.flit_tail_i = '0;
        u_if.free_signal_i = '0;
        chk("t3 wait_free", {63'h0, u_if.vc_state_o[0]}, 64'h0);
        cyc("t3 hold", 6'b000000);
        chk("t3 still busy", {63'h0, u_if.vc_state_o[0]}, 64'h0);
        u_if.free_signal_i = 6'b000001;
        cyc("t3 free", 6'b000000);
        u_if.free_signal_i = '0;
        chk("t3 freed", {63'h0, u_if.vc_state_o[0]}, 64'h1);
        u_if.bind_i = 6'b000001;
        u_if.bind_buffer_id_i[0 +: 3] = 3'd5;
        cyc("t3 rebind", 6'b000000);
        u_if.bind_i = '0;
        chk("t3 id vc0", {61'h0, u_if.fifo_pointed_o[2:0]}, 64'd5);
        u_if.credit_signal_i = 6'b000001;
        cyc("t3 ret", 6'b000000);
        u_if.credit_signal_i = '0;

        // 4: grant and credit together on VC2
        u_if.bind_i = 6'b000100;
        u_if.bind_buffer_id_i[6 +: 3] = 3'd4;
        cyc("t4 bind", 6'b000000);
        u_if.bind_i = '0;
        u_if.flit_req_i = 6'b000100;
        u_if.credit_signal_i = 6'b000100;
        cyc("t4 net", 6'b000100);
        u_if.credit_signal_i = '0;
        for (int i = 0; i < 4; i++) cyc("t4 send", 6'b000100);
        cyc("t4 stall", 6'b000000);
        u_if.flit_req_i = '0;

        // 5: bind and free on a BOUND VC are ignored
        u_if.bind_i = 6'b000010;
        u_if.bind_buffer_id_i[3 +: 3] = 3'd7;
        u_if.free_signal_i = 6'b000010;
        cyc("t5 rebind", 6'b000000);
        u_if.bind_i = '0;
        u_if.free_signal_i = '0;
        chk("t5 id vc1", {61'h0, u_if.fifo_pointed_o[5:3]}, 64'd3);
        chk("t5 vc1 busy", {63'h0, u_if.vc_state_o[1]}, 64'h0);

        // three-way round robin, pointer at VC3
        u_if.flit_req_i = 6'b001011;
        cyc("rr 0", 6'b001000);
        cyc("rr 1", 6'b000001);
        cyc("rr 2", 6'b000010);
        cyc("rr 3", 6'b001000);
        u_if.flit_req_i = '0;

        // 6: reset mid-packet
        u_if.flit_req_i = 6'b000010;
        cyc("t6 head", 6'b000010);
        rst = 1'b0;
        cyc("t6 rst", 6'b000000);
        rst = 1'b1;
        u_if.flit_req_i = '0;
        chk("t6 valid", {63'h0, u_if.is_valid_o}, 64'h0);
        chk("t6 vc_state", {58'h0, u_if.vc_state_o}, 64'h3F);
        chk("t6 fifo", {46'h0, u_if.fifo_pointed_o}, 64'h0);
        u_if.bind_i = 6'b000010;
        u_if.bind_buffer_id_i[3 +: 3] = 3'd1;
        u_if.flit_req_i = 6'b000010;
        cyc("t6 bind", 6'b000000);
        u_if.bind_i = '0;
        for (int i = 0; i < 4; i++) cyc("t6 send", 6'b000010);
        cyc("t6 stall", 6'b000000);
        u_if.flit_req_i = '0;
        cyc("drain", 6'b000000);
        chk("sb empty", 64'(sb_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
